line_buffer_writer: RTL and testbench

LINE_BUFFER_WRITER -- requirements
Module: line_buffer_writer

---
 rtl/line_buffer_writer.sv | 131 +++++++++++++
 tb/tb_line_buffer_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_writer.sv
// Double-banked line buffer writer: packs a pixel stream into one bank while the display reads
// the other. Define LINE_BUFFER_WRITER_UNDERRUN_EN to enable the sticky underrun flag.
module line_buffer_writer #(
  parameter int unsigned LINE_WIDTH  = 320,
  parameter int unsigned BANK_OFFSET = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        line_finished,
  output logic [12:0] mem_address,
  output logic [11:0] mem_data,
  output logic        mem_write,
  output logic        write_bank,
  output logic        line_ready,
  output logic        underrun,
  input  logic        underrun_clear
);

  localparam logic [12:0] LastIdx = 13'(LINE_WIDTH - 1);
  localparam logic [12:0] BankOff = 13'(BANK_OFFSET);

  typedef enum logic {StFill, StWaitSwap} state_e;

  state_e      r_state, w_state_nxt;
  logic [12:0] r_index, w_index_nxt;
  logic        r_write_bank, w_bank_nxt;
  logic        r_line_ready, w_line_ready_nxt;
  logic        r_mem_write, w_mem_write_nxt;
  logic [12:0] r_mem_address, w_mem_address_nxt;
  logic [11:0] r_mem_data, w_mem_data_nxt;
  logic        w_xfer, w_last, w_underrun_set;

  assign w_xfer = pixel_valid && (r_state == StFill);
  assign w_last = w_xfer && (r_index == LastIdx);

  always_comb begin
    w_state_nxt       = r_state;
    w_index_nxt       = r_index;
    w_bank_nxt        = r_write_bank;
    w_line_ready_nxt  = r_line_ready;
    w_mem_write_nxt   = 1'b0;
    w_mem_address_nxt = r_mem_address;
    w_mem_data_nxt    = r_mem_data;
    w_underrun_set    = 1'b0;
    unique case (r_state)
      StFill: begin
        if (w_xfer) begin
          w_mem_write_nxt   = 1'b1;
          w_mem_data_nxt    = pixel_data;
          w_mem_address_nxt = r_index + (r_write_bank ? BankOff : 13'd0);
          if (w_last) begin
            w_index_nxt = 13'd0;
            // A swap arriving with the final pixel is honoured at once: no wait state.
            if (line_finished) begin
              w_bank_nxt = ~r_write_bank;
            end else begin
              w_state_nxt      = StWaitSwap;
              w_line_ready_nxt = 1'b1;
            end
          end else begin
            w_index_nxt = r_index + 13'd1;
          end
        end
        if (line_finished && !w_last) begin
          w_underrun_set = 1'b1;
        end
      end
      StWaitSwap: begin
        if (line_finished) begin
          w_state_nxt      = StFill;
          w_index_nxt      = 13'd0;
          w_bank_nxt       = ~r_write_bank;
          w_line_ready_nxt = 1'b0;
        end
      end
      default: w_state_nxt = StFill;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StFill;
      r_index       <= 13'd0;
      r_write_bank  <= 1'b0;
      r_line_ready  <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 13'd0;
      r_mem_data    <= 12'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_index       <= w_index_nxt;
      r_write_bank  <= w_bank_nxt;
      r_line_ready  <= w_line_ready_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_data    <= w_mem_data_nxt;
    end
  end

`ifdef LINE_BUFFER_WRITER_UNDERRUN_EN
  logic r_underrun;

  // Set has priority over a coincident clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end else if (underrun_clear) begin
      r_underrun <= 1'b0;
    end
  end

  assign underrun = r_underrun;
`else
  logic w_unused_underrun;
  assign w_unused_underrun = underrun_clear ^ w_underrun_set;
  assign underrun          = 1'b0;
`endif

  assign pixel_ready = (r_state == StFill);
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_write   = r_mem_write;
  assign write_bank  = r_write_bank;
  assign line_ready  = r_line_ready;

endmodule

// File: tb/tb_line_buffer_writer.sv
// Self-checking bench for line_buffer_writer: a pixel-count model checked every cycle plus
// directed literal checks for reset, swap, coincident swap, underrun, mid-line reset, backpressure.
module tb_line_buffer_writer;

  localparam int unsigned Width  = 320;
  localparam int unsigned Offset = 4096;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        line_finished;
  logic [12:0] mem_address;
  logic [11:0] mem_data;
  logic        mem_write;
  logic        write_bank;
  logic        line_ready;
  logic        underrun;
  logic        underrun_clear;

  int n_tests = 0;
  int n_fail  = 0;
  bit compare_on = 1'b0;

`ifdef LINE_BUFFER_WRITER_UNDERRUN_EN
  localparam logic UnrExp = 1'b1;
`else
  localparam logic UnrExp = 1'b0;
`endif

  line_buffer_writer #(
    .LINE_WIDTH (Width),
    .BANK_OFFSET(Offset)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .pixel_ready   (pixel_ready),
    .line_finished (line_finished),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .mem_write     (mem_write),
    .write_bank    (write_bank),
    .line_ready    (line_ready),
    .underrun      (underrun),
    .underrun_clear(underrun_clear)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks how many pixels the current line holds and whether it is full.
  int          m_count;
  bit          m_full;
  bit          m_bank;
  bit          m_unr;
  bit          m_wr;
  int          m_addr;
  logic [11:0] m_data;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0; m_full = 0; m_bank = 0; m_unr = 0;
      m_wr = 0; m_addr = 0; m_data = '0;
    end else begin
      bit set_unr;
      set_unr = 0;
      m_wr = 0;
      if (!m_full && pixel_valid) begin
        m_wr   = 1;
        m_addr = m_count + (m_bank ? Offset : 0);
        m_data = pixel_data;
        m_count++;
        if (m_count == Width) begin
          m_count = 0;
          if (line_finished) m_bank = !m_bank;
          else m_full = 1;
        end else if (line_finished) begin
          set_unr = 1;
        end
      end else if (m_full) begin
        if (line_finished) begin
          m_bank = !m_bank; m_count = 0; m_full = 0;
        end
      end else if (line_finished) begin
        set_unr = 1;
      end
      if (UnrExp) begin
        if (set_unr) m_unr = 1;
        else if (underrun_clear) m_unr = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (compare_on) begin
      chk("mem_write", 32'(mem_write), 32'(m_wr));
      chk("mem_address", 32'(mem_address), 32'(m_addr));
      chk("mem_data", 32'(mem_data), 32'(m_data));
      chk("write_bank", 32'(write_bank), 32'(m_bank));
      chk("line_ready", 32'(line_ready), 32'(m_full));
      chk("pixel_ready", 32'(pixel_ready), 32'(!m_full));
      chk("underrun", 32'(underrun), 32'(m_unr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n_xfer;
    int n_wr;
    int last_addr;
    reset_n = 1'b0; pixel_data = '0; pixel_valid = 1'b0;
    line_finished = 1'b0; underrun_clear = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst mem_write", 32'(mem_write), 0);
    chk("rst mem_address", 32'(mem_address), 0);
    chk("rst mem_data", 32'(mem_data), 0);
    chk("rst write_bank", 32'(write_bank), 0);
    chk("rst line_ready", 32'(line_ready), 0);
    chk("rst underrun", 32'(underrun), 0);
    chk("rst pixel_ready", 32'(pixel_ready), 1);
    compare_on = 1'b1;
    reset_n = 1'b1;

    // Full line 0x000..0x13F into bank 0.
    for (int i = 0; i < 320; i++) begin
      pixel_valid = 1'b1; pixel_data = 12'(i);
      @(negedge clock);
      if (i == 0) chk("first write addr", 32'(mem_address), 0);
    end
    chk("last write addr", 32'(mem_address), 319);
    chk("last write data", 32'(mem_data), 32'h13F);
    chk("line_ready after line", 32'(line_ready), 1);
    chk("pixel_ready after line", 32'(pixel_ready), 0);
    pixel_data = 12'h555;
    repeat (3) @(negedge clock);
    chk("no write while waiting", 32'(mem_write), 0);

    // Swap then write 0xABC at bank 1 base.
    pixel_valid = 1'b0; line_finished = 1'b1;
    @(negedge clock);
    line_finished = 1'b0;
    chk("swap bank", 32'(write_bank), 1);
    chk("swap line_ready", 32'(line_ready), 0);
    pixel_valid = 1'b1; pixel_data = 12'hABC;
    @(negedge clock);
    pixel_valid = 1'b0;
    chk("swap write", 32'(mem_write), 1);
    chk("swap addr", 32'(mem_address), 4096);
    chk("swap data", 32'(mem_data), 32'hABC);

    // Finish bank 1 with line_finished coincident on the last pixel.
    for (int i = 1; i < 320; i++) begin
      pixel_valid = 1'b1; pixel_data = 12'(i) | 12'h800;
      line_finished = (i == 319);
      @(negedge clock);
    end
    line_finished = 1'b0;
    chk("coinc last addr", 32'(mem_address), 4415);
    chk("coinc bank", 32'(write_bank), 0);
    chk("coinc line_ready", 32'(line_ready), 0);
    chk("coinc underrun", 32'(underrun), 0);
    pixel_data = 12'h321;
    @(negedge clock);
    chk("coinc next addr", 32'(mem_address), 0);
    chk("coinc next data", 32'(mem_data), 32'h321);

    // Underrun: line_finished after 100 pixels.
    for (int i = 1; i < 100; i++) begin
      pixel_data = 12'(i);
      @(negedge clock);
    end
    pixel_valid = 1'b0; line_finished = 1'b1;
    @(negedge clock);
    line_finished = 1'b0;
    @(negedge clock);
    chk("unr bank", 32'(write_bank), 0);
    chk("unr flag", 32'(underrun), 32'(UnrExp));
    pixel_valid = 1'b1; pixel_data = 12'h777;
    @(negedge clock);
    pixel_valid = 1'b0;
    chk("unr next addr", 32'(mem_address), 100);
    underrun_clear = 1'b1;
    @(negedge clock);
    underrun_clear = 1'b0;
    chk("unr cleared", 32'(underrun), 0);
    line_finished = 1'b1; underrun_clear = 1'b1;
    @(negedge clock);
    line_finished = 1'b0; underrun_clear = 1'b0;
    chk("unr set beats clear", 32'(underrun), 32'(UnrExp));
    underrun_clear = 1'b1;
    @(negedge clock);
    underrun_clear = 1'b0;

    // Complete bank 0, swap, then 50 pixels into bank 1 and reset mid-line.
    for (int i = 101; i < 320; i++) begin
      pixel_valid = 1'b1; pixel_data = 12'(i);
      @(negedge clock);
    end
    pixel_valid = 1'b0; line_finished = 1'b1;
    @(negedge clock);
    line_finished = 1'b0;
    for (int i = 0; i < 50; i++) begin
      pixel_valid = 1'b1; pixel_data = 12'h400 + 12'(i);
      @(negedge clock);
    end
    chk("pre-reset addr", 32'(mem_address), 4096 + 49);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst mem_write", 32'(mem_write), 0);
    chk("midrst addr", 32'(mem_address), 0);
    chk("midrst data", 32'(mem_data), 0);
    chk("midrst bank", 32'(write_bank), 0);
    chk("midrst line_ready", 32'(line_ready), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1; pixel_data = 12'h0AA;
    @(negedge clock);
    pixel_valid = 1'b0;
    chk("post-reset write", 32'(mem_write), 1);
    chk("post-reset addr", 32'(mem_address), 0);
    chk("post-reset data", 32'(mem_data), 32'h0AA);

    // Backpressure: random valid, one write per transfer, contiguous from index 1.
    n_xfer = 0; n_wr = 0; last_addr = 0;
    for (int i = 0; i < 200; i++) begin
      pixel_valid = 1'($urandom_range(0, 1));
      pixel_data  = 12'($urandom);
      if (pixel_valid) n_xfer++;
      @(negedge clock);
      if (mem_write) begin
        n_wr++;
        last_addr = int'(mem_address);
      end
    end
    pixel_valid = 1'b0;
    @(negedge clock);
    chk("bp write count", 32'(n_wr), 32'(n_xfer));
    if (n_xfer > 0) chk("bp last addr", 32'(last_addr), 32'(n_xfer));

    compare_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
